data_mem_access: RTL and testbench

Memory-side consumer of the decoded load/store type vectors. Takes one CPU access (one-hot load/unsigned-load/store type, byte address, store data), drives a word-addressed data-memory bus with byte enables and a req/ack handshake, and returns a sign- or zero-extended load result. Accesses crossing a word boundary are split into two bus beats. Sits between the execute/memory pipeline stage and data memory; stalls the pipeline via `oBusy`.

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/byte_lane_align.sv | 37 +++
 rtl/data_mem_access.sv | 157 +++++++++++++++
 tb/tb_data_mem_access.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory access unit.
package lsu_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // One-hot bit positions within iLoadTypes[3:1], iULoadTypes[2:1], iStoreTypes[3:1]
  localparam int LD_LB   = 1;
  localparam int LD_LH   = 2;
  localparam int LD_LW   = 3;
  localparam int ULD_LBU = 1;
  localparam int ULD_LHU = 2;
  localparam int ST_SB   = 1;
  localparam int ST_SH   = 2;
  localparam int ST_SW   = 3;

  localparam logic [3:0] SIZE_MASK_B = 4'b0001;
  localparam logic [3:0] SIZE_MASK_H = 4'b0011;
  localparam logic [3:0] SIZE_MASK_W = 4'b1111;

  function automatic logic [3:0] size_mask(size_t s);
    case (s)
      SZ_B:    return SIZE_MASK_B;
      SZ_H:    return SIZE_MASK_H;
      default: return SIZE_MASK_W;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(size_t s);
    case (s)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Byte-lane steering for one bus beat: byte enables, write-data shift and
// read-lane extraction toward the low bytes of the assembled result.
module byte_lane_align
  import lsu_pkg::*;
(
  input  size_t       i_size,
  input  logic [1:0]  i_off,
  input  logic        i_beat1,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rlane
);

  logic [2:0] w_inv;
  logic [5:0] w_sh0;
  logic [5:0] w_sh1;

  assign w_inv = 3'd4 - {1'b0, i_off};
  assign w_sh0 = {1'b0, i_off, 3'b000};
  assign w_sh1 = {w_inv, 3'b000};

  // Beat 1 carries the bytes that spilled past lane 3 of beat 0
  always_comb begin
    if (i_beat1) begin
      o_be    = size_mask(i_size) >> w_inv;
      o_wdata = i_wdata >> w_sh1;
      o_rlane = i_rdata << w_sh1;
    end else begin
      o_be    = size_mask(i_size) << i_off;
      o_wdata = i_wdata << w_sh0;
      o_rlane = i_rdata >> w_sh0;
    end
  end

endmodule

// File: rtl/data_mem_access.sv
// CPU load/store to word-addressed data memory: one or two bus beats per
// access, byte enables, and sign/zero extension of the load result.
module data_mem_access
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iReq,
  input  logic [3:1]        iLoadTypes,
  input  logic [2:1]        iULoadTypes,
  input  logic [3:1]        iStoreTypes,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [31:0]       iWData,
  output logic              oBusy,
  output logic              oDone,
  output logic [31:0]       oRData,
  output logic              oFault,
  output logic              oMemReq,
  output logic              oMemWe,
  output logic [ADDR_W-3:0] oMemAddr,
  output logic [3:0]        oMemBe,
  output logic [31:0]       oMemWData,
  input  logic              iMemAck,
  input  logic [31:0]       iMemRData
);

  state_t              r_state;
  size_t               r_size;
  logic [1:0]          r_off;
  logic [ADDR_W-3:0]   r_word;
  logic [31:0]         r_wdata;
  logic [31:0]         r_acc;
  logic                r_store;
  logic                r_uns;
  logic                r_split;

  logic                w_legal;
  size_t               w_in_size;
  logic                w_in_split;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [31:0]         w_rlane;
  logic [31:0]         w_asm;
  logic [31:0]         w_ext;

  assign w_legal = $onehot({iStoreTypes, iULoadTypes, iLoadTypes});

  always_comb begin
    if (iLoadTypes[LD_LW] || iStoreTypes[ST_SW])
      w_in_size = SZ_W;
    else if (iLoadTypes[LD_LH] || iULoadTypes[ULD_LHU] || iStoreTypes[ST_SH])
      w_in_size = SZ_H;
    else
      w_in_size = SZ_B;
  end

  assign w_in_split = ({1'b0, iAddr[1:0]} + size_bytes(w_in_size)) > 3'd4;

  byte_lane_align u_align (
    .i_size  (r_size),
    .i_off   (r_off),
    .i_beat1 (r_state == S_ACC1),
    .i_wdata (r_wdata),
    .i_rdata (iMemRData),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_rlane (w_rlane)
  );

  assign w_asm = (r_state == S_ACC1) ? (r_acc | w_rlane) : w_rlane;

  always_comb begin
    w_ext = w_asm;
    case (r_size)
      SZ_B:    w_ext = r_uns ? {24'd0, w_asm[7:0]}  : {{24{w_asm[7]}}, w_asm[7:0]};
      SZ_H:    w_ext = r_uns ? {16'd0, w_asm[15:0]} : {{16{w_asm[15]}}, w_asm[15:0]};
      default: w_ext = w_asm;
    endcase
    if (r_store) w_ext = 32'd0;
  end

  assign oBusy     = (r_state != S_IDLE);
  assign oMemWe    = oMemReq & r_store;
  assign oMemAddr  = oMemReq ? r_word : '0;
  assign oMemBe    = oMemReq ? w_be : 4'd0;
  assign oMemWData = oMemWe ? w_wdata : 32'd0;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= S_IDLE;
      r_size  <= SZ_B;
      r_off   <= 2'd0;
      r_word  <= '0;
      r_wdata <= 32'd0;
      r_acc   <= 32'd0;
      r_store <= 1'b0;
      r_uns   <= 1'b0;
      r_split <= 1'b0;
      oMemReq <= 1'b0;
      oDone   <= 1'b0;
      oRData  <= 32'd0;
      oFault  <= 1'b0;
    end else begin
      oDone  <= 1'b0;
      oRData <= 32'd0;
      oFault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iReq) begin
            r_size  <= w_in_size;
            r_off   <= iAddr[1:0];
            r_word  <= iAddr[ADDR_W-1:2];
            r_wdata <= iWData;
            r_store <= |iStoreTypes;
            r_uns   <= |iULoadTypes;
            r_split <= w_in_split;
            r_acc   <= 32'd0;
            if (w_legal) begin
              r_state <= S_ACC0;
              oMemReq <= 1'b1;
            end else begin
              r_state <= S_RESP;
              oDone   <= 1'b1;
              oFault  <= 1'b1;
            end
          end
        end
        S_ACC0: begin
          if (iMemAck) begin
            r_acc <= w_rlane;
            if (r_split) begin
              r_state <= S_ACC1;
              r_word  <= r_word + 1'b1;
            end else begin
              r_state <= S_RESP;
              oMemReq <= 1'b0;
              oDone   <= 1'b1;
              oRData  <= w_ext;
            end
          end
        end
        S_ACC1: begin
          if (iMemAck) begin
            r_state <= S_RESP;
            oMemReq <= 1'b0;
            oDone   <= 1'b1;
            oRData  <= w_ext;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_access.sv
// Randomized and directed bench for data_mem_access against a byte-level memory model.
module tb_data_mem_access;

  logic        iClk = 1'b0;
  logic        iRstN;
  logic        iReq;
  logic [3:1]  iLoadTypes;
  logic [2:1]  iULoadTypes;
  logic [3:1]  iStoreTypes;
  logic [31:0] iAddr;
  logic [31:0] iWData;
  logic        oBusy, oDone, oFault, oMemReq, oMemWe;
  logic [31:0] oRData, oMemWData;
  logic [29:0] oMemAddr;
  logic [3:0]  oMemBe;
  logic        iMemAck;
  logic [31:0] iMemRData;

  always #5 iClk = ~iClk;

  data_mem_access #(.ADDR_W(32)) dut (
    .iClk(iClk), .iRstN(iRstN), .iReq(iReq),
    .iLoadTypes(iLoadTypes), .iULoadTypes(iULoadTypes), .iStoreTypes(iStoreTypes),
    .iAddr(iAddr), .iWData(iWData),
    .oBusy(oBusy), .oDone(oDone), .oRData(oRData), .oFault(oFault),
    .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemBe(oMemBe),
    .oMemWData(oMemWData), .iMemAck(iMemAck), .iMemRData(iMemRData)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bus-side word memory (written by the responder) and reference byte memory
  bit [31:0] mem_w [bit [29:0]];
  bit [7:0]  ref_b [bit [31:0]];

  function automatic bit [31:0] init_word(bit [29:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic bit [31:0] bus_read(bit [29:0] a);
    return mem_w.exists(a) ? mem_w[a] : init_word(a);
  endfunction

  function automatic bit [7:0] ref_read(bit [31:0] ba);
    bit [31:0] w;
    if (ref_b.exists(ba)) return ref_b[ba];
    w = init_word(ba[31:2]);
    return w[8*ba[1:0] +: 8];
  endfunction

  function automatic bit [31:0] be2mask(bit [3:0] be);
    bit [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic preload(input bit [29:0] word, input bit [31:0] val);
    mem_w[word] = val;
    for (int i = 0; i < 4; i++) ref_b[{word, 2'(i)}] = val[8*i +: 8];
  endtask

  int        beats;
  bit [29:0] b_addr [2];
  bit [3:0]  b_be   [2];
  bit [31:0] b_wd   [2];

  task automatic run_access(input bit [3:1] ld, input bit [2:1] uld, input bit [3:1] st,
                            input bit [31:0] addr, input bit [31:0] wd,
                            input int minw, input int maxw,
                            output bit [31:0] rd, output bit flt,
                            output int cyc, output int waits);
    bit        done = 1'b0;
    bit        fresh = 1'b1;
    int        wl;
    bit [29:0] h_a;
    bit [3:0]  h_be;
    bit [31:0] h_wd;
    bit [31:0] w;
    rd = 32'd0; flt = 1'b0; cyc = 0; waits = 0; beats = 0;
    wl = $urandom_range(maxw, minw);
    iLoadTypes = ld; iULoadTypes = uld; iStoreTypes = st;
    iAddr = addr; iWData = wd; iReq = 1'b1; iMemAck = 1'b0;
    while (!done && cyc < 100) begin
      @(posedge iClk); #1; cyc++;
      if (oDone) begin
        rd = oRData; flt = oFault; done = 1'b1; iMemAck = 1'b0;
      end else if (oMemReq) begin
        if (fresh) begin
          h_a = oMemAddr; h_be = oMemBe; h_wd = oMemWData; fresh = 1'b0;
        end else begin
          check("stable_addr", 32'(oMemAddr), 32'(h_a));
          check("stable_be", 32'(oMemBe), 32'(h_be));
          check("stable_wdata", oMemWData, h_wd);
        end
        if (wl == 0) begin
          iMemAck = 1'b1;
          iMemRData = bus_read(oMemAddr);
          if (oMemWe) begin
            w = bus_read(oMemAddr);
            w = (w & ~be2mask(oMemBe)) | (oMemWData & be2mask(oMemBe));
            mem_w[oMemAddr] = w;
          end
          if (beats < 2) begin
            b_addr[beats] = oMemAddr; b_be[beats] = oMemBe; b_wd[beats] = oMemWData;
          end
          beats++;
          fresh = 1'b1;
          wl = $urandom_range(maxw, minw);
        end else begin
          iMemAck = 1'b0; wl--; waits++;
        end
      end else begin
        iMemAck = 1'b0;
      end
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    iReq = 1'b0; iMemAck = 1'b0;
    iLoadTypes = '0; iULoadTypes = '0; iStoreTypes = '0;
    @(posedge iClk); #1;
  endtask

  // Reference expectations derived from byte addresses and type semantics
  task automatic do_check(input string tag, input bit [3:1] ld, input bit [2:1] uld,
                          input bit [3:1] st, input bit [31:0] addr, input bit [31:0] wd,
                          input int minw, input int maxw, output int cyc_o);
    bit [31:0] rd, v, exp_rd, ba;
    bit        flt, legal;
    int        cyc, waits, sz, nb, k;
    bit [29:0] ea [2];
    bit [3:0]  ebe [2];
    bit [31:0] ewd [2];
    legal = ($countones({ld, uld, st}) == 1);
    run_access(ld, uld, st, addr, wd, minw, maxw, rd, flt, cyc, waits);
    cyc_o = cyc;
    if (!legal) begin
      check({tag, ".fault"}, 32'(flt), 32'd1);
      check({tag, ".rdata"}, rd, 32'd0);
      check({tag, ".beats"}, 32'(beats), 32'd0);
      check({tag, ".lat"}, 32'(cyc), 32'd1);
    end else begin
      sz = (ld[3] | st[3]) ? 4 : (ld[2] | uld[2] | st[2]) ? 2 : 1;
      v = 32'd0;
      for (int j = 0; j < 2; j++) begin ea[j] = '0; ebe[j] = '0; ewd[j] = '0; end
      for (int i = 0; i < sz; i++) begin
        ba = addr + 32'(i);
        k = (ba[31:2] == addr[31:2]) ? 0 : 1;
        ea[k] = ba[31:2];
        ebe[k][ba[1:0]] = 1'b1;
        ewd[k][8*ba[1:0] +: 8] = wd[8*i +: 8];
        v[8*i +: 8] = ref_read(ba);
      end
      nb = (ebe[1] != 4'd0) ? 2 : 1;
      check({tag, ".beats"}, 32'(beats), 32'(nb));
      for (int j = 0; j < nb && j < beats; j++) begin
        check({tag, ".addr"}, 32'(b_addr[j]), 32'(ea[j]));
        check({tag, ".be"}, 32'(b_be[j]), 32'(ebe[j]));
        if (st != 3'd0) check({tag, ".wdata"}, b_wd[j] & be2mask(ebe[j]), ewd[j]);
      end
      if (ld[3])       exp_rd = v;
      else if (ld[2])  exp_rd = {{16{v[15]}}, v[15:0]};
      else if (ld[1])  exp_rd = {{24{v[7]}}, v[7:0]};
      else if (uld[2]) exp_rd = {16'd0, v[15:0]};
      else if (uld[1]) exp_rd = {24'd0, v[7:0]};
      else             exp_rd = 32'd0;
      check({tag, ".rdata"}, rd, exp_rd);
      check({tag, ".fault"}, 32'(flt), 32'd0);
      check({tag, ".lat"}, 32'(cyc), 32'(1 + nb + waits));
      if (st != 3'd0)
        for (int i = 0; i < sz; i++) ref_b[addr + 32'(i)] = wd[8*i +: 8];
    end
  endtask

  initial begin
    int        cyc, dn;
    bit [7:0]  t;
    bit [31:0] a;
    iRstN = 1'b0; iReq = 1'b0; iLoadTypes = '0; iULoadTypes = '0; iStoreTypes = '0;
    iAddr = '0; iWData = '0; iMemAck = 1'b0; iMemRData = '0;
    repeat (3) @(posedge iClk);
    #1;
    check("rst.busy", 32'(oBusy), 32'd0);
    check("rst.done", 32'(oDone), 32'd0);
    check("rst.rdata", oRData, 32'd0);
    check("rst.fault", 32'(oFault), 32'd0);
    check("rst.memreq", 32'(oMemReq), 32'd0);
    check("rst.bus", {oMemWe, oMemBe, oMemAddr[26:0]} | oMemWData, 32'd0);
    @(negedge iClk); iRstN = 1'b1;
    @(posedge iClk); #1;

    do_check("sw", 3'b000, 2'b00, 3'b100, 32'h1000, 32'hDEADBEEF, 0, 0, cyc);
    check("sw.addr0", 32'(b_addr[0]), 32'h400);
    check("sw.be0", 32'(b_be[0]), 32'hF);
    check("sw.wd0", b_wd[0], 32'hDEADBEEF);
    check("sw.done2", 32'(cyc), 32'd2);

    preload(30'h400, 32'h80FF_FF12);
    do_check("lb", 3'b001, 2'b00, 3'b000, 32'h1003, 32'h0, 0, 0, cyc);
    check("lb.be", 32'(b_be[0]), 32'h8);
    do_check("lbu", 3'b000, 2'b01, 3'b000, 32'h1003, 32'h0, 0, 0, cyc);

    preload(30'h400, 32'h1122_3344);
    preload(30'h401, 32'h5566_7788);
    do_check("lw_split", 3'b100, 2'b00, 3'b000, 32'h1002, 32'h0, 0, 0, cyc);
    check("lw_split.be0", 32'(b_be[0]), 32'hC);
    check("lw_split.be1", 32'(b_be[1]), 32'h3);

    do_check("sh3", 3'b000, 2'b00, 3'b010, 32'h0003, 32'h0000ABCD, 0, 1, cyc);
    check("sh3.w0", 32'(b_addr[0]), 32'd0);
    check("sh3.d0", 32'(b_wd[0][31:24]), 32'hCD);
    check("sh3.w1", 32'(b_addr[1]), 32'd1);
    check("sh3.d1", 32'(b_wd[1][7:0]), 32'hAB);
    do_check("sw_wrap", 3'b000, 2'b00, 3'b100, 32'hFFFFFFFE, 32'hCAFEF00D, 0, 1, cyc);
    check("sw_wrap.w1", 32'(b_addr[1]), 32'd0);

    do_check("lb_sb", 3'b001, 2'b00, 3'b001, 32'h1000, 32'h0, 0, 0, cyc);
    do_check("notype", 3'b000, 2'b00, 3'b000, 32'h1000, 32'h0, 0, 0, cyc);

    do_check("wait5", 3'b100, 2'b00, 3'b000, 32'h1004, 32'h0, 5, 5, cyc);
    check("wait5.lat", 32'(cyc), 32'd7);

    // Reset asserted in the third cycle of an unacknowledged access
    iLoadTypes = 3'b100; iAddr = 32'h1008; iReq = 1'b1; iMemAck = 1'b0;
    repeat (3) begin @(posedge iClk); #1; end
    #2 iRstN = 1'b0;
    #1;
    check("abort.memreq", 32'(oMemReq), 32'd0);
    check("abort.busy", 32'(oBusy), 32'd0);
    iReq = 1'b0; iLoadTypes = '0;
    dn = 0;
    repeat (2) begin @(posedge iClk); #1; if (oDone) dn++; end
    @(negedge iClk); iRstN = 1'b1;
    repeat (4) begin @(posedge iClk); #1; if (oDone) dn++; end
    check("abort.nodone", 32'(dn), 32'd0);
    do_check("after_rst", 3'b000, 2'b00, 3'b010, 32'h1006, 32'h00005A5A, 0, 0, cyc);
    do_check("after_rst_ld", 3'b010, 2'b00, 3'b000, 32'h1006, 32'h0, 0, 0, cyc);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(7, 0) != 0) t = 8'd1 << $urandom_range(7, 0);
      else t = 8'($urandom);
      if ($urandom_range(7, 0) == 0) a = 32'hFFFF_FFF8 + $urandom_range(7, 0);
      else a = 32'h1000 + $urandom_range(47, 0);
      do_check("rnd", t[2:0], t[4:3], t[7:5], a, $urandom, 0, 3, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
